// File: rtl/he_pkg.sv
// he_pkg: shared state encoding, bin geometry and default frame size for the
// histogram-equalisation controller.
`default_nettype none

package he_pkg;

    localparam int HE_IMG_W      = 660;
    localparam int HE_IMG_H      = 440;
    localparam int HE_NUM_PIXELS = HE_IMG_W * HE_IMG_H;
    localparam int HE_NUM_BINS   = 256;
    localparam int HE_ADDR_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_HIST_RD = 3'd2,
        ST_HIST_WR = 3'd3,
        ST_CDF_RD  = 3'd4,
        ST_CDF_WR  = 3'd5,
        ST_MAP     = 3'd6
    } he_state_e;

endpackage

`default_nettype wire

// File: rtl/he_bin_ram.sv
// he_bin_ram: single-port histogram bin RAM, synchronous read, 1-cycle latency.
`default_nettype none

module he_bin_ram
    import he_pkg::*;
#(
    parameter int DEPTH = HE_NUM_BINS,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [HE_ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/he_ctrl.sv
// he_ctrl: frame histogram -> CDF lookup table -> per-pixel equalisation,
// sharing one bin RAM between clear, histogram and CDF phases.
`default_nettype none

module he_ctrl
    import he_pkg::*;
#(
    parameter int NUM_PIXELS = HE_NUM_PIXELS,
    parameter int NUM_BINS   = HE_NUM_BINS,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_pixel,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    localparam int PW = CNT_W + 8;

    he_state_e              r_state, w_next;
    logic [HE_ADDR_W-1:0]   r_idx, r_pix;
    logic [CNT_W-1:0]       r_in_cnt, r_out_cnt, r_acc;
    logic                   r_out_valid, r_done;
    logic [7:0]             r_out_pixel;
    logic [7:0]             r_lut [NUM_BINS];

    logic                   w_ram_en, w_ram_we;
    logic [HE_ADDR_W-1:0]   w_ram_addr;
    logic [CNT_W-1:0]       w_ram_wdata, w_ram_rdata;
    logic                   w_in_ready, w_in_fire, w_out_fire;
    logic                   w_idx_last, w_hist_last, w_out_last;
    logic [CNT_W-1:0]       w_sum;
    logic [PW-1:0]          w_quot;
    logic [7:0]             w_lut_val;

    he_bin_ram #(.DEPTH(NUM_BINS), .WIDTH(CNT_W)) u_bin_ram (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    assign w_idx_last  = (r_idx == HE_ADDR_W'(NUM_BINS - 1));
    assign w_hist_last = (r_in_cnt == CNT_W'(NUM_PIXELS));
    assign w_out_last  = (r_out_cnt == CNT_W'(NUM_PIXELS - 1));
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;

    // Running CDF scaled to 0..255; the quotient only exceeds 255 on bad parameters.
    assign w_sum     = r_acc + w_ram_rdata;
    assign w_quot    = (PW'(w_sum) * PW'(255)) / PW'(NUM_PIXELS);
    assign w_lut_val = (w_quot > PW'(255)) ? 8'hFF : w_quot[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_idx;
        w_ram_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_ram_en = 1'b1;
                w_ram_we = 1'b1;
                if (w_idx_last) w_next = ST_HIST_RD;
            end
            ST_HIST_RD: begin
                w_in_ready = 1'b1;
                w_ram_en   = in_valid;
                w_ram_addr = in_pixel;
                if (in_valid) w_next = ST_HIST_WR;
            end
            ST_HIST_WR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = r_pix;
                w_ram_wdata = w_ram_rdata + CNT_W'(1);
                w_next      = w_hist_last ? ST_CDF_RD : ST_HIST_RD;
            end
            ST_CDF_RD: begin
                w_ram_en = 1'b1;
                w_next   = ST_CDF_WR;
            end
            ST_CDF_WR: begin
                if (w_idx_last) w_next = ST_MAP;
                else            w_next = ST_CDF_RD;
            end
            ST_MAP: begin
                w_in_ready = (r_in_cnt != CNT_W'(NUM_PIXELS)) && (!r_out_valid || out_ready);
                if (w_out_fire && w_out_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_pix       <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_acc     <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                ST_HIST_RD: begin
                    if (in_valid) begin
                        r_pix    <= in_pixel;
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                end
                ST_HIST_WR: begin
                    if (w_hist_last) begin
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                ST_CDF_WR: begin
                    r_acc <= w_sum;
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                    if (w_idx_last) begin
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                    end
                end
                ST_MAP: begin
                    if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
                    if (w_in_fire)  r_in_cnt  <= r_in_cnt + 1'b1;
                    if (w_out_fire && w_out_last) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (w_in_fire) begin
                        r_out_pixel <= r_lut[in_pixel];
                        r_out_valid <= 1'b1;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // LUT is fully rewritten during CDF each frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_CDF_WR) r_lut[r_idx] <= w_lut_val;
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign phase     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_he_ctrl.sv
// tb_he_ctrl: directed frames with hand-computed equalised outputs, NUM_PIXELS=16.
`default_nettype none

module tb_he_ctrl;
    import he_pkg::*;

    localparam int NP = 16;

    logic       clk, reset, start, in_valid, out_ready;
    logic [7:0] in_pixel;
    logic       in_ready, out_valid, busy, done;
    logic [7:0] out_pixel;
    logic [2:0] phase;

    int n_cmp, n_err;
    logic [7:0] hp[NP], mp[NP], ep[NP];

    he_ctrl #(.NUM_PIXELS(NP), .NUM_BINS(256), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .out_valid(out_valid), .out_pixel(out_pixel), .out_ready(out_ready),
        .busy(busy), .done(done), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_busy"},      {31'd0, busy},      0);
        chk({tag, "_done"},      {31'd0, done},      0);
        chk({tag, "_out_pixel"}, {24'd0, out_pixel}, 0);
        chk({tag, "_phase"},     {29'd0, phase},     0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one frame from negedge to negedge; gap/stall/mid_start add stress.
    task automatic run_frame(input string tag, input bit gap, input bit stall, input bit mid_start);
        int hi = 0, mi = 0, nout = 0, clr = 0, cdf = 0, last_hs = -10, done_cyc = -1;
        int bad_rdy = 0, bad_hold = 0, stall_cnt = 0;
        bit fin = 0, held = 0, mid_sent = 0;
        logic [7:0] held_pix = 8'd0;
        pulse_start();
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (phase == 3'(ST_CLEAR)) clr++;
            if (phase == 3'(ST_CDF_RD) || phase == 3'(ST_CDF_WR)) cdf++;
            if (in_ready && phase != 3'(ST_HIST_RD) && phase != 3'(ST_MAP)) bad_rdy++;
            if (held && (!out_valid || out_pixel != held_pix)) bad_hold++;
            if (done) begin
                done_cyc = cyc;
                fin = 1;
                chk({tag, "_idle_after_done"}, {29'd0, phase}, 0);
                chk({tag, "_ovalid_after_done"}, {31'd0, out_valid}, 0);
            end else begin
                start = 1'b0;
                if (mid_start && !mid_sent && phase == 3'(ST_HIST_RD) && hi == 5) begin
                    start = 1'b1;
                    mid_sent = 1;
                end
                if (phase == 3'(ST_HIST_RD)) begin
                    in_valid = (hi < NP) && (!gap || (cyc % 2 == 0));
                    in_pixel = (hi < NP) ? hp[hi] : 8'hAA;
                end else if (phase == 3'(ST_MAP) && mi < NP) begin
                    in_valid = 1'b1;
                    in_pixel = mp[mi];
                end else begin
                    in_valid = 1'b1;
                    in_pixel = 8'hAA;
                end
                out_ready = 1'b1;
                if (stall && nout == 3 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end
                #1;
                if (in_valid && in_ready) begin
                    if (phase == 3'(ST_HIST_RD)) hi++;
                    else if (phase == 3'(ST_MAP)) mi++;
                end
                held = 0;
                if (out_valid && !out_ready) begin
                    if (in_ready) bad_rdy++;
                    held = 1;
                    held_pix = out_pixel;
                end
                if (out_valid && out_ready) begin
                    if (nout < NP) chk($sformatf("%s_out%0d", tag, nout), {24'd0, out_pixel}, {24'd0, ep[nout]});
                    nout++;
                    last_hs = cyc;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, fin}, 1);
        chk({tag, "_clear_cycles"}, clr, 256);
        chk({tag, "_cdf_cycles"}, cdf, 512);
        chk({tag, "_done_latency"}, done_cyc - last_hs, 1);
        chk({tag, "_out_count"}, nout, NP);
        chk({tag, "_map_accepted"}, mi, NP);
        chk({tag, "_in_ready_illegal"}, bad_rdy, 0);
        if (stall) begin
            chk({tag, "_stall_cycles"}, stall_cnt, 5);
            chk({tag, "_hold_violations"}, bad_hold, 0);
        end
    endtask

    initial begin
        logic [7:0] m8[8], e8[8];
        bit ok;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        out_ready = 1'b1;
        #12;
        chk_idle_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // Frame A: 16x value 100 -> lut[0..99]=0, lut[100..255]=255.
        m8 = '{8'd0, 8'd99, 8'd100, 8'd255, 8'd50, 8'd101, 8'd200, 8'd100};
        e8 = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255};
        for (int i = 0; i < NP; i++) begin
            hp[i] = 8'd100;
            mp[i] = m8[i % 8];
            ep[i] = e8[i % 8];
        end
        run_frame("fa", 0, 0, 0);

        // Abort mid-histogram with a different pixel value.
        pulse_start();
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            if (phase == 3'(ST_HIST_RD)) ok = 1;
            else @(negedge clk);
        end
        chk("rst_reach_hist", {31'd0, ok}, 1);
        in_valid = 1'b1;
        in_pixel = 8'd7;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        run_frame("fa2", 0, 0, 0);

        // Frame B: pixels 0..15 -> lut[k]=floor(255*(k+1)/16), with output stall.
        m8 = '{8'd0, 8'd7, 8'd15, 8'd1, 8'd3, 8'd8, 8'd14, 8'd200};
        e8 = '{8'd15, 8'd127, 8'd255, 8'd31, 8'd63, 8'd143, 8'd239, 8'd255};
        for (int i = 0; i < NP; i++) begin
            hp[i] = 8'(i);
            mp[i] = m8[i % 8];
            ep[i] = e8[i % 8];
        end
        run_frame("fb", 0, 1, 0);

        // Frame C: 8x5 + 8x250, gapped input and a stray start mid-histogram.
        m8 = '{8'd0, 8'd4, 8'd5, 8'd6, 8'd249, 8'd250, 8'd255, 8'd100};
        e8 = '{8'd0, 8'd0, 8'd127, 8'd127, 8'd127, 8'd255, 8'd255, 8'd127};
        for (int i = 0; i < NP; i++) begin
            hp[i] = (i < 8) ? 8'd5 : 8'd250;
            mp[i] = m8[i % 8];
            ep[i] = e8[i % 8];
        end
        run_frame("fc", 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
